winker_stalk_encoder: RTL and testbench
=======================================

# winker_stalk_encoder

Command-side front end for the turn-signal controller. It converts the raw steering-column stalk and cancel-button contacts into the clean, single-cycle `left_winker` / `right_winker` / `off` command pulses that the winker controller consumes. It also tracks which direction it has commanded, so stalk toggles, the cancel button, an on-time timeout and optional steering-return auto-cancel all map to correct command sequences. It sits between the board-level switch inputs and the winker controller, on the same `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronized samples required before a contact level is accepted (≥1).
- `ANGLE_W`, 8: width of signed steering angle.
- `ARM_THRESH`, 30: steering magnitude that arms auto-cancel.
- `CENTER_BAND`, 5: magnitude at or below which the wheel counts as centred (< `ARM_THRESH`).
- `MAX_ON_CYCLES`, 1000000: active-state timeout in cycles; 0 disables. Counter is 24 bits.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low; clock `clk`.
- `lever_left_n` in 1: raw stalk-left contact, active-low, asynchronous.
- `lever_right_n` in 1: raw stalk-right contact, active-low, asynchronous.
- `cancel_n` in 1: raw cancel button, active-low, asynchronous.
- `steer_angle` in `ANGLE_W`: signed two's complement; negative = left.
- `left_winker` out 1: one-cycle left command pulse.
- `right_winker` out 1: one-cycle right command pulse.
- `off` out 1: one-cycle off command pulse.
- `active_dir` out 2: 00 idle, 01 left, 10 right (11 never driven).
- `armed` out 1: auto-cancel armed.

## Operation
- Each raw input passes through a 2-flop synchronizer, then a per-input debouncer. The debounced level changes only after `DEBOUNCE_CYCLES` consecutive identical synchronized samples that differ from the current level. A mismatch restarts that input's count.
- A press event is a debounced transition from released to pressed. Releases generate nothing.
- FSM states: IDLE, LEFT, RIGHT.
  - IDLE: left press pulses `left_winker` and moves to LEFT. Right press pulses `right_winker` and moves to RIGHT. Cancel is ignored.
  - LEFT: left press pulses `off` and moves to IDLE (toggle). Right press pulses `right_winker` and moves to RIGHT. Cancel pulses `off` and moves to IDLE.
  - RIGHT: mirror image of LEFT.
- Priority within one cycle: cancel > timeout > auto-cancel > lever presses.
- Simultaneous left and right press events in the same cycle are both discarded.
- At most one of the three command outputs is high in any cycle.
- Timeout: the on-counter clears on every state entry and increments each cycle in LEFT/RIGHT. When it reaches `MAX_ON_CYCLES`, the block pulses `off` and moves to IDLE. No counter wrap is possible.
- `active_dir` reflects the registered state.

## Timing
- Reset values: all pulses 0, `active_dir`=00, `armed`=0, state IDLE. Debounced levels reset to released; counters reset to 0.
- Reset mid-operation: outputs clear immediately and no `off` is emitted. A lever already held at reset release must be debounced (`DEBOUNCE_CYCLES` cycles) before it produces a press.
- Latency: a raw edge sampled at cycle 0 and held stable gives a command pulse in cycle `DEBOUNCE_CYCLES`+3. `active_dir` updates in the same cycle as the pulse.
- Pulses are exactly 1 cycle wide. A held lever produces one pulse only.
- Timeout `off` occurs exactly `MAX_ON_CYCLES` cycles after the entry pulse.

## Configuration
- `WINKER_AUTO_CANCEL_EN` defined:
  - In LEFT, `steer_angle` ≤ −`ARM_THRESH` sets `armed`. In RIGHT, `steer_angle` ≥ `ARM_THRESH` sets it.
  - While `armed`, |`steer_angle`| ≤ `CENTER_BAND` pulses `off` in the next cycle, moves to IDLE and clears `armed`.
  - `armed` also clears on any state change.
  - −2^(`ANGLE_W`−1) is treated as magnitude 2^(`ANGLE_W`−1).
- Undefined: `steer_angle` is ignored, `armed` is tied to 0, and no steering logic is synthesized.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `MAX_ON_CYCLES`=100, `WINKER_AUTO_CANCEL_EN` defined.
- Left lever held low 20 cycles with 3-cycle glitches before it → exactly one `left_winker` pulse 7 cycles after the stable edge; `active_dir`=01; glitches produce nothing.
- LEFT, then right press → one `right_winker` pulse, no `off`, `active_dir`=10. A second right press → `off` pulse, `active_dir`=00.
- LEFT, cancel and right pressed in the same cycle → `off` only, IDLE. Cancel in IDLE → no output.
- LEFT, no further input → `off` exactly 100 cycles after the `left_winker` pulse.
- LEFT, `steer_angle`=−40 → `armed`=1; then angle=−3 → `off` next cycle, `armed`=0. Angle +40 while in LEFT → `armed` stays 0.
- `reset_n` pulsed low while in RIGHT → all outputs 0 asynchronously, no `off` pulse, `active_dir`=00.

Source files
------------

// File: rtl/winker_stalk_encoder.sv
`default_nettype none
// ============================================================================
// Module      : winker_stalk_encoder
// Description : Turns raw stalk-left / stalk-right / cancel contacts into
//               clean single-cycle left_winker / right_winker / off command
//               pulses. Tracks the commanded direction and handles the
//               toggle, cancel, on-time timeout and (optionally) steering
//               return auto-cancel.
//               Optional feature macro: WINKER_AUTO_CANCEL_EN
//               (steering-return auto-cancel; disabled when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module winker_stalk_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ANGLE_W         = 8,
  parameter int ARM_THRESH      = 30,
  parameter int CENTER_BAND     = 5,
  parameter int MAX_ON_CYCLES   = 1000000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               lever_left_n,
  input  logic               lever_right_n,
  input  logic               cancel_n,
  input  logic [ANGLE_W-1:0] steer_angle,
  output logic               left_winker,
  output logic               right_winker,
  output logic               off,
  output logic [1:0]         active_dir,
  output logic               armed
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int              DB_W    = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam bit          TIMEOUT_EN  = (MAX_ON_CYCLES != 0);
  localparam logic [23:0] MAX_ON_LAST = 24'(MAX_ON_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LEFT  = 2'b01,
    ST_RIGHT = 2'b10
  } state_t;

  // Raw contacts converted to active-high "pressed": bit0 left, bit1 right,
  // bit2 cancel.
  logic [2:0] raw_pressed;
  assign raw_pressed = ~{cancel_n, lever_right_n, lever_left_n};

  logic [2:0] press_d;
  logic [2:0] press_q;

  for (genvar gi = 0; gi < 3; gi++) begin : g_input
    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic            level_d;
    logic            prev_q;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
    // differing samples; any agreeing sample restarts the count.
    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
        if (cnt_q == DB_LAST) begin
          level_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Two-flop synchronizer, debounced level and edge-detect history.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        level_q <= 1'b0;
        prev_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= raw_pressed[gi];
        sync2_q <= sync1_q;
        level_q <= level_d;
        prev_q  <= level_q;
        cnt_q   <= cnt_d;
      end
    end

    // Released-to-pressed transition of the debounced level.
    assign press_d[gi] = level_q & ~prev_q;
  end

  // Register press events so the command pulse lands DEBOUNCE_CYCLES+3
  // cycles after the raw edge is first sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_q <= '0;
    end else begin
      press_q <= press_d;
    end
  end

  // Simultaneous left and right presses cancel each other out.
  logic press_left;
  logic press_right;
  logic press_cancel;
  assign press_left   = press_q[0] & ~press_q[1];
  assign press_right  = press_q[1] & ~press_q[0];
  assign press_cancel = press_q[2];

  logic arm_left;
  logic arm_right;
  logic centred;

`ifdef WINKER_AUTO_CANCEL_EN
  localparam logic [ANGLE_W:0] ARM_MAG    = (ANGLE_W+1)'(ARM_THRESH);
  localparam logic [ANGLE_W:0] CENTER_MAG = (ANGLE_W+1)'(CENTER_BAND);

  // One extra bit so the most negative angle has a representable magnitude.
  logic             angle_neg;
  logic [ANGLE_W:0] angle_ext;
  logic [ANGLE_W:0] angle_mag;
  assign angle_neg = steer_angle[ANGLE_W-1];
  assign angle_ext = {angle_neg, steer_angle};
  assign angle_mag = angle_neg ? (~angle_ext + 1'b1) : angle_ext;

  assign arm_left  = angle_neg  && (angle_mag >= ARM_MAG);
  assign arm_right = !angle_neg && (angle_mag >= ARM_MAG);
  assign centred   = (angle_mag <= CENTER_MAG);
`else
  logic unused_steer;
  assign unused_steer = ^{steer_angle, ARM_THRESH[0], CENTER_BAND[0]};
  assign arm_left     = 1'b0;
  assign arm_right    = 1'b0;
  assign centred      = 1'b0;
`endif

  state_t      state_q;
  state_t      state_d;
  logic        left_winker_q;
  logic        left_winker_d;
  logic        right_winker_q;
  logic        right_winker_d;
  logic        off_q;
  logic        off_d;
  logic        armed_q;
  logic        armed_d;
  logic [23:0] on_cnt_q;
  logic [23:0] on_cnt_d;

  logic timeout;
  logic auto_off;
  assign timeout  = TIMEOUT_EN && (state_q != ST_IDLE) && (on_cnt_q == MAX_ON_LAST);
  assign auto_off = armed_q && centred;

  // Next-state and command-pulse decode. Cancel, timeout and auto-cancel
  // all resolve to "off and go idle", so they outrank lever presses as one
  // group; the arming check only runs when nothing else happens.
  always_comb begin
    state_d        = state_q;
    left_winker_d  = 1'b0;
    right_winker_d = 1'b0;
    off_d          = 1'b0;
    armed_d        = armed_q;
    on_cnt_d       = on_cnt_q;
    if (TIMEOUT_EN && (state_q != ST_IDLE)) begin
      on_cnt_d = on_cnt_q + 24'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (press_left) begin
          left_winker_d = 1'b1;
          state_d       = ST_LEFT;
        end else if (press_right) begin
          right_winker_d = 1'b1;
          state_d        = ST_RIGHT;
        end
      end
      ST_LEFT: begin
        if (press_cancel || timeout || auto_off || press_left) begin
          off_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (press_right) begin
          right_winker_d = 1'b1;
          state_d        = ST_RIGHT;
        end else if (arm_left) begin
          armed_d = 1'b1;
        end
      end
      ST_RIGHT: begin
        if (press_cancel || timeout || auto_off || press_right) begin
          off_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (press_left) begin
          left_winker_d = 1'b1;
          state_d       = ST_LEFT;
        end else if (arm_right) begin
          armed_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Every state entry restarts the on-time and drops any arming.
    if (state_d != state_q) begin
      on_cnt_d = '0;
      armed_d  = 1'b0;
    end
  end

  // State, pulse, arming and on-time registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      left_winker_q  <= 1'b0;
      right_winker_q <= 1'b0;
      off_q          <= 1'b0;
      armed_q        <= 1'b0;
      on_cnt_q       <= '0;
    end else begin
      state_q        <= state_d;
      left_winker_q  <= left_winker_d;
      right_winker_q <= right_winker_d;
      off_q          <= off_d;
      armed_q        <= armed_d;
      on_cnt_q       <= on_cnt_d;
    end
  end

  assign left_winker  = left_winker_q;
  assign right_winker = right_winker_q;
  assign off          = off_q;
  assign active_dir   = state_q;
  assign armed        = armed_q;

endmodule
`default_nettype wire

// File: tb/tb_winker_stalk_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_winker_stalk_encoder
// Description : Self-checking bench for winker_stalk_encoder. Expected
//               command pulses (kind, direction, cycle) are queued when the
//               stimulus is driven and compared when a pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_winker_stalk_encoder;

  localparam int DEB    = 4;
  localparam int MAXON  = 100;
  localparam int LAT    = DEB + 4;  // drive at a negedge -> pulse seen LAT negedges later
  localparam int K_LEFT  = 1;
  localparam int K_RIGHT = 2;
  localparam int K_OFF   = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       lever_left_n = 1'b1;
  logic       lever_right_n = 1'b1;
  logic       cancel_n = 1'b1;
  logic [7:0] steer_angle = 8'd0;
  logic       left_winker;
  logic       right_winker;
  logic       off;
  logic [1:0] active_dir;
  logic       armed;

  winker_stalk_encoder #(
    .DEBOUNCE_CYCLES(DEB),
    .ANGLE_W        (8),
    .ARM_THRESH     (30),
    .CENTER_BAND    (5),
    .MAX_ON_CYCLES  (MAXON)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .lever_left_n (lever_left_n),
    .lever_right_n(lever_right_n),
    .cancel_n     (cancel_n),
    .steer_angle  (steer_angle),
    .left_winker  (left_winker),
    .right_winker (right_winker),
    .off          (off),
    .active_dir   (active_dir),
    .armed        (armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [1:0] dir;
    int         cyc;
  } exp_t;

  // mask: bit0 left, bit1 right, bit2 cancel
  typedef struct {
    logic [2:0] mask;
    int         kind;
    logic [1:0] dir;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[15];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Compare any pulse on the outputs against the head of the scoreboard.
  task automatic monitor();
    int   kind;
    exp_t e;
    kind = 0;
    if (left_winker === 1'b1)       kind = K_LEFT;
    else if (right_winker === 1'b1) kind = K_RIGHT;
    else if (off === 1'b1)          kind = K_OFF;
    if (kind != 0) begin
      check("pulse_onehot", $countones({left_winker, right_winker, off}), 1);
      if (sb.size() == 0) begin
        check("unexpected_pulse", kind, 0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", kind, e.kind);
        check("pulse_dir", active_dir, e.dir);
        check("pulse_cycle", cyc, e.cyc);
      end
    end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
      e = sb.pop_front();
      check("missing_pulse", 0, e.kind);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic drive(input logic [2:0] mask);
    lever_left_n  = ~mask[0];
    lever_right_n = ~mask[1];
    cancel_n      = ~mask[2];
  endtask

  task automatic press(input logic [2:0] mask, input int hold);
    drive(mask);
    repeat (hold) tick();
    drive(3'b000);
    repeat (DEB + 5) tick();
  endtask

  task automatic expect_pulse(input int kind, input logic [1:0] dir, input int delay);
    exp_t e;
    e.kind = kind;
    e.dir  = dir;
    e.cyc  = cyc + delay;
    sb.push_back(e);
  endtask

  initial begin
    vecs[0]  = '{3'b001, K_LEFT,  2'b01};  // idle -> left
    vecs[1]  = '{3'b010, K_RIGHT, 2'b10};  // left -> right, no off
    vecs[2]  = '{3'b010, K_OFF,   2'b00};  // right toggle off
    vecs[3]  = '{3'b100, 0,       2'b00};  // cancel in idle ignored
    vecs[4]  = '{3'b010, K_RIGHT, 2'b10};
    vecs[5]  = '{3'b001, K_LEFT,  2'b01};  // right -> left
    vecs[6]  = '{3'b001, K_OFF,   2'b00};  // left toggle off
    vecs[7]  = '{3'b011, 0,       2'b00};  // simultaneous L+R discarded
    vecs[8]  = '{3'b001, K_LEFT,  2'b01};
    vecs[9]  = '{3'b110, K_OFF,   2'b00};  // cancel beats right press
    vecs[10] = '{3'b010, K_RIGHT, 2'b10};
    vecs[11] = '{3'b100, K_OFF,   2'b00};  // cancel from right
    vecs[12] = '{3'b010, K_RIGHT, 2'b10};
    vecs[13] = '{3'b011, 0,       2'b10};  // L+R discarded while active
    vecs[14] = '{3'b100, K_OFF,   2'b00};

    // Reset state
    repeat (3) tick();
    check("reset_pulses", {left_winker, right_winker, off}, 3'b000);
    check("reset_dir", active_dir, 2'b00);
    check("reset_armed", armed, 1'b0);
    reset_n = 1'b1;
    repeat (3) tick();

    // Short glitches shorter than the debounce window produce nothing
    repeat (2) begin
      drive(3'b001);
      repeat (DEB - 1) tick();
      drive(3'b000);
      repeat (3) tick();
    end
    repeat (6) tick();
    check("glitch_dir", active_dir, 2'b00);

    // Stable hold: exactly one pulse, DEB+3 cycles after first sample
    expect_pulse(K_LEFT, 2'b01, LAT);
    press(3'b001, 20);
    check("held_dir", active_dir, 2'b01);
    expect_pulse(K_OFF, 2'b00, LAT);
    press(3'b100, DEB + 6);
    check("held_cancel_dir", active_dir, 2'b00);

    // Table-driven lever/cancel sequences
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].kind != 0) expect_pulse(vecs[i].kind, vecs[i].dir, LAT);
      press(vecs[i].mask, DEB + 6);
      check($sformatf("vec%0d_dir", i), active_dir, vecs[i].dir);
    end

    // On-time timeout exactly MAXON cycles after the entry pulse
    expect_pulse(K_LEFT, 2'b01, LAT);
    expect_pulse(K_OFF, 2'b00, LAT + MAXON);
    press(3'b001, DEB + 6);
    repeat (MAXON) tick();
    check("timeout_dir", active_dir, 2'b00);

`ifdef WINKER_AUTO_CANCEL_EN
    // Auto-cancel: wrong-side angle does not arm, correct side does
    expect_pulse(K_LEFT, 2'b01, LAT);
    press(3'b001, DEB + 6);
    steer_angle = 8'd40;
    repeat (3) tick();
    check("arm_wrong_side", armed, 1'b0);
    steer_angle = 8'(-40);
    tick();
    check("arm_left", armed, 1'b1);
    steer_angle = 8'(-3);
    expect_pulse(K_OFF, 2'b00, 1);
    tick();
    check("auto_off_armed_clear", armed, 1'b0);
    check("auto_off_dir", active_dir, 2'b00);
    steer_angle = 8'd0;
    repeat (3) tick();

    // Right side: exact thresholds, negative angle does not arm
    expect_pulse(K_RIGHT, 2'b10, LAT);
    press(3'b010, DEB + 6);
    steer_angle = 8'h80;
    repeat (2) tick();
    check("arm_right_neg", armed, 1'b0);
    steer_angle = 8'd30;
    tick();
    check("arm_right_thresh", armed, 1'b1);
    steer_angle = 8'd5;
    expect_pulse(K_OFF, 2'b00, 1);
    tick();
    check("band_edge_clear", armed, 1'b0);
    steer_angle = 8'd0;
    repeat (3) tick();

    // Most negative angle arms; state change clears arming
    expect_pulse(K_LEFT, 2'b01, LAT);
    press(3'b001, DEB + 6);
    steer_angle = 8'h80;
    tick();
    check("arm_min_angle", armed, 1'b1);
    steer_angle = 8'd6;
    repeat (2) tick();
    check("armed_outside_band", armed, 1'b1);
    expect_pulse(K_RIGHT, 2'b10, LAT);
    press(3'b010, DEB + 6);
    check("armed_clear_on_change", armed, 1'b0);
    steer_angle = 8'd0;
    expect_pulse(K_OFF, 2'b00, LAT);
    press(3'b100, DEB + 6);
`else
    // Without auto-cancel the steering input has no effect
    expect_pulse(K_LEFT, 2'b01, LAT);
    press(3'b001, DEB + 6);
    steer_angle = 8'(-40);
    repeat (3) tick();
    check("no_arm", armed, 1'b0);
    steer_angle = 8'(-3);
    repeat (3) tick();
    check("no_auto_off_dir", active_dir, 2'b01);
    steer_angle = 8'd0;
    expect_pulse(K_OFF, 2'b00, LAT);
    press(3'b100, DEB + 6);
`endif

    // Asynchronous reset while in RIGHT; lever held across reset release
    expect_pulse(K_RIGHT, 2'b10, LAT);
    press(3'b010, DEB + 6);
    check("pre_reset_dir", active_dir, 2'b10);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_dir", active_dir, 2'b00);
    check("async_reset_pulses", {left_winker, right_winker, off}, 3'b000);
    drive(3'b001);
    repeat (4) tick();
    reset_n = 1'b1;
    expect_pulse(K_LEFT, 2'b01, LAT);
    repeat (DEB + 6) tick();
    drive(3'b000);
    repeat (DEB + 5) tick();
    check("post_reset_dir", active_dir, 2'b01);
    expect_pulse(K_OFF, 2'b00, LAT);
    press(3'b100, DEB + 6);

    repeat (5) tick();
    check("leftover_expectations", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
